// File: rtl/br_pred_btb_lru.sv
// Fully-associative BTB with 2-bit direction counters and true-LRU replacement.
// Optional same-cycle update-to-lookup bypass: define BR_PRED_BTB_BYPASS_EN.
module br_pred_btb_lru #(
  parameter  int ENTRIES = 8,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  logic          valid [ENTRIES];
  logic [31:0]   tag   [ENTRIES];
  logic [31:0]   tgt   [ENTRIES];
  logic [1:0]    ctr   [ENTRIES];
  logic [AW-1:0] age   [ENTRIES];

  logic          lk_found;
  logic [AW-1:0] lk_idx;
  logic          upd_found;
  logic [AW-1:0] upd_idx;
  logic          inv_found;
  logic [AW-1:0] inv_idx;
  logic [AW-1:0] lru_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [1:0]    new_ctr;
  logic [31:0]   new_tgt;
  logic [31:0]   seq_pc;

  assign seq_pc = lk_pc + 32'd4;

  // Descending scans so the lowest matching index is the one kept.
  always_comb begin
    lk_found  = 1'b0;
    lk_idx    = '0;
    upd_found = 1'b0;
    upd_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == lk_pc) begin
        lk_found = 1'b1;
        lk_idx   = AW'(i);
      end
      if (valid[i] && tag[i] == upd_pc) begin
        upd_found = 1'b1;
        upd_idx   = AW'(i);
      end
      if (!valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = AW'(i);
      end
      if (age[i] == AW'(ENTRIES - 1))
        lru_idx = AW'(i);
    end
  end

  always_comb begin
    wr_en   = upd_valid && (upd_found || upd_taken);
    wr_idx  = upd_found ? upd_idx : (inv_found ? inv_idx : lru_idx);
    new_ctr = 2'b10;
    new_tgt = upd_target;
    if (upd_found) begin
      new_ctr = ctr[upd_idx];
      if (upd_taken && ctr[upd_idx] != 2'b11)
        new_ctr = ctr[upd_idx] + 2'd1;
      else if (!upd_taken && ctr[upd_idx] != 2'b00)
        new_ctr = ctr[upd_idx] - 2'd1;
      if (!upd_taken)
        new_tgt = tgt[upd_idx];
    end
  end

  always_comb begin
    lk_hit    = 1'b0;
    lk_taken  = 1'b0;
    lk_target = seq_pc;
    if (lk_valid && !rst) begin
`ifdef BR_PRED_BTB_BYPASS_EN
      if (wr_en && !flush && upd_pc == lk_pc) begin
        lk_hit   = 1'b1;
        lk_taken = new_ctr[1];
        if (new_ctr[1])
          lk_target = new_tgt;
      end else
`endif
      if (lk_found) begin
        lk_hit   = 1'b1;
        lk_taken = ctr[lk_idx][1];
        if (ctr[lk_idx][1])
          lk_target = tgt[lk_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        tag[i]   <= '0;
        tgt[i]   <= '0;
        ctr[i]   <= 2'b01;
        age[i]   <= AW'(i);
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        age[i]   <= AW'(i);
      end
    end else if (wr_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (AW'(i) == wr_idx)
          age[i] <= '0;
        else if (age[i] < age[wr_idx])
          age[i] <= age[i] + AW'(1);
      end
      valid[wr_idx] <= 1'b1;
      tag[wr_idx]   <= upd_pc;
      tgt[wr_idx]   <= new_tgt;
      ctr[wr_idx]   <= new_ctr;
    end
  end

endmodule
